// File: rtl/nor_sweep_pkg.sv
// -----------------------------------------------------------------------------
// nor_sweep_pkg
// Shared types and helpers for the switch-level NOR exhaustive-sweep checker.
//   state_t      : checker FSM states (IDLE, DRIVE, CHECK, DONE)
//   MAX_N        : widest NOR the checker supports
//   MAX_HOLD     : longest settle window per vector
//   MAX_REPEAT   : most full sweeps per start
//   nor_ref(vec) : behavioural reference, ~|vec
// Optional feature macro used elsewhere: NOR_SWEEP_FAULT_INJ_EN
// -----------------------------------------------------------------------------
package nor_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int MAX_N      = 8;
  localparam int MAX_HOLD   = 15;
  localparam int MAX_REPEAT = 255;

  // Callers zero-extend narrower vectors; the extra zero bits do not change a NOR.
  function automatic logic nor_ref(input logic [MAX_N-1:0] vec);
    return ~|vec;
  endfunction

endpackage

// File: rtl/nor_sweep_chk_if.sv
// -----------------------------------------------------------------------------
// nor_sweep_chk_if
// Control/status bundle of the NOR sweep checker.
//   start         : one-cycle run request (master -> slave)
//   inj           : force a mismatch on the current CHECK (only when
//                   NOR_SWEEP_FAULT_INJ_EN is defined)
//   vec_o         : vector driven into the switch NOR
//   dut_o         : raw switch NOR output
//   busy, done    : run in progress / one-cycle completion pulse
//   err_cnt       : saturating mismatch counter
//   err_flag      : sticky, err_cnt nonzero
//   first_err_vec : vector of the first mismatch of the run
// slave = checker side, master = requester side.
// -----------------------------------------------------------------------------
interface nor_sweep_chk_if #(
  parameter int N  = 2,
  parameter int CW = 16
);
  logic          start;
`ifdef NOR_SWEEP_FAULT_INJ_EN
  logic          inj;
`endif
  logic [N-1:0]  vec_o;
  logic          dut_o;
  logic          busy;
  logic          done;
  logic [CW-1:0] err_cnt;
  logic          err_flag;
  logic [N-1:0]  first_err_vec;

`ifdef NOR_SWEEP_FAULT_INJ_EN
  modport slave (
    input  start, inj,
    output vec_o, dut_o, busy, done, err_cnt, err_flag, first_err_vec
  );
  modport master (
    output start, inj,
    input  vec_o, dut_o, busy, done, err_cnt, err_flag, first_err_vec
  );
`else
  modport slave (
    input  start,
    output vec_o, dut_o, busy, done, err_cnt, err_flag, first_err_vec
  );
  modport master (
    output start,
    input  vec_o, dut_o, busy, done, err_cnt, err_flag, first_err_vec
  );
`endif

endinterface

// File: rtl/nor_n_sw.sv
// -----------------------------------------------------------------------------
// nor_n_sw
// Switch-level N-input NOR (pure combinational, no clock).
//   in  [N-1:0] : NOR inputs
//   out         : NOR output
// Pull-up: series pmos chain from supply1, one device per input.
// Pull-down: N parallel nmos from the output node to supply0.
// -----------------------------------------------------------------------------
module nor_n_sw #(
  parameter int N = 2
) (
  input  wire [N-1:0] in,
  output wire         out
);

  supply1 vdd;
  supply0 gnd;

  // w_chain[gi] is the node below pmos gi; w_chain[N-1] is the output node.
  wire [N-1:0] w_chain;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        pmos u_p (w_chain[gi], vdd, in[gi]);
      end else begin : g_next
        pmos u_p (w_chain[gi], w_chain[gi-1], in[gi]);
      end
      nmos u_n (w_chain[N-1], gnd, in[gi]);
    end
  endgenerate

  assign out = w_chain[N-1];

endmodule

// File: rtl/nor_sweep_chk.sv
// -----------------------------------------------------------------------------
// nor_sweep_chk
// Exhaustive-sweep self-checker around the switch-level NOR nor_n_sw.
// Drives vectors 0..2^N-1 (REPEAT times), holds each for HOLD cycles, then
// compares the switch output against ~|vec with case equality, so X/Z on
// the switch output count as mismatches.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : nor_sweep_chk_if.slave (start[, inj], vec_o, dut_o, busy, done,
//           err_cnt, err_flag, first_err_vec)
// Parameters: N (1..8), HOLD (1..15), REPEAT (1..255), CW (error counter width)
// Optional macro NOR_SWEEP_FAULT_INJ_EN: inj=1 during CHECK inverts the
// compared switch output, forcing a mismatch on that vector.
// -----------------------------------------------------------------------------
module nor_sweep_chk
  import nor_sweep_pkg::*;
#(
  parameter int N      = 2,
  parameter int HOLD   = 1,
  parameter int REPEAT = 1,
  parameter int CW     = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  nor_sweep_chk_if.slave  bus
);

  state_t        r_state;
  // One spare MSB so the increment past 2^N-1 flags the end of a sweep.
  logic [N:0]    r_vec;
  logic [3:0]    r_hold;
  logic [7:0]    r_sweep;
  logic          r_busy;
  logic          r_done;
  logic [CW-1:0] r_err_cnt;
  logic          r_err_flag;
  logic [N-1:0]  r_first_err_vec;

  wire           w_dut;
  logic          w_cmp;
  logic          w_exp;
  logic          w_mismatch;
  logic [N:0]    w_vec_inc;

  nor_n_sw #(.N(N)) u_nor (
    .in  (r_vec[N-1:0]),
    .out (w_dut)
  );

`ifdef NOR_SWEEP_FAULT_INJ_EN
  assign w_cmp = w_dut ^ bus.inj;
`else
  assign w_cmp = w_dut;
`endif

  assign w_exp      = nor_ref(MAX_N'(r_vec[N-1:0]));
  assign w_mismatch = (w_cmp !== w_exp);
  assign w_vec_inc  = r_vec + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= IDLE;
      r_vec           <= '0;
      r_hold          <= '0;
      r_sweep         <= '0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_err_cnt       <= '0;
      r_err_flag      <= 1'b0;
      r_first_err_vec <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_state         <= DRIVE;
            r_vec           <= '0;
            r_hold          <= '0;
            r_sweep         <= '0;
            r_busy          <= 1'b1;
            r_err_cnt       <= '0;
            r_err_flag      <= 1'b0;
            r_first_err_vec <= '0;
          end
        end

        DRIVE: begin
          if (r_hold == 4'(HOLD - 1)) begin
            r_hold  <= '0;
            r_state <= CHECK;
          end else begin
            r_hold <= r_hold + 4'd1;
          end
        end

        CHECK: begin
          if (w_mismatch) begin
            if (r_err_cnt != {CW{1'b1}}) begin
              r_err_cnt <= r_err_cnt + 1'b1;
            end
            // err_flag doubles as "a mismatch already seen this run".
            if (!r_err_flag) begin
              r_err_flag      <= 1'b1;
              r_first_err_vec <= r_vec[N-1:0];
            end
          end
          if (!w_vec_inc[N]) begin
            r_vec   <= w_vec_inc;
            r_state <= DRIVE;
          end else if (r_sweep != 8'(REPEAT - 1)) begin
            r_vec   <= '0;
            r_sweep <= r_sweep + 8'd1;
            r_state <= DRIVE;
          end else begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end
        end

        DONE: begin
          // vec_o keeps the last swept vector until the next run.
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.vec_o         = r_vec[N-1:0];
  assign bus.dut_o         = w_dut;
  assign bus.busy          = r_busy;
  assign bus.done          = r_done;
  assign bus.err_cnt       = r_err_cnt;
  assign bus.err_flag      = r_err_flag;
  assign bus.first_err_vec = r_first_err_vec;

endmodule
